// File: rtl/seg_chain_driver.sv
// seg_chain_driver: serialises a NUM_DIGITS*SEG_WIDTH-bit segment frame into
// an external shift-register chain (sclk_o / data_o / latch_o). Supports a
// programmable serial-clock divider, a selectable bit order and a one-deep
// pending-frame buffer with overrun reporting.
// Optional: define SEG_CHAIN_DRIVER_DIM_EN to add brightness_i / oe_n_o PWM
// dimming. Without it the board ties the chain's OE pin low (always on).
module seg_chain_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int SEG_WIDTH    = 7,
  parameter int SCLK_DIV     = 1,
  parameter int LATCH_CYCLES = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [NUM_DIGITS*SEG_WIDTH-1:0] data_i,
  input  logic                            lsb_first_i,
`ifdef SEG_CHAIN_DRIVER_DIM_EN
  input  logic [3:0]                      brightness_i,
  output logic                            oe_n_o,
`endif
  output logic                            busy_o,
  output logic                            sclk_o,
  output logic                            data_o,
  output logic                            latch_o,
  output logic                            frame_done_o,
  output logic                            overrun_o
);

  localparam int W  = NUM_DIGITS * SEG_WIDTH;
  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t        state;
  logic [W-1:0]  act_q;    // active frame, current bit at MSB
  logic [W-1:0]  pend_q;   // queued frame, already in transmit order
  logic          pend_v;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [LW-1:0] lat_cnt;

  logic [W-1:0]  data_ord;
  logic [W-1:0]  act_shl;
  logic [W-1:0]  launch_data;
  logic          div_done;
  logic          lat_done;

  // Put the incoming frame in transmit order so the shifter always sends MSB first
  always_comb begin
    data_ord = data_i;
    if (lsb_first_i)
      for (int i = 0; i < W; i++) data_ord[i] = data_i[W-1-i];
  end

  assign act_shl     = act_q << 1;
  assign div_done    = (div_cnt == DIV_LAST);
  assign lat_done    = (state == LATCH) && (lat_cnt == LAT_LAST);
  // At the end of LATCH a queued frame wins; otherwise a same-cycle start goes straight out
  assign launch_data = pend_v ? pend_q : data_ord;

  // Main sequencer: shift, clock divider, latch and back-to-back relaunch
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      act_q        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      lat_cnt      <= '0;
      busy_o       <= 1'b0;
      sclk_o       <= 1'b0;
      data_o       <= 1'b0;
      latch_o      <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            act_q   <= data_ord;
            data_o  <= data_ord[W-1];
            busy_o  <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk_o  <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              data_o  <= 1'b0;
              latch_o <= 1'b1;
              lat_cnt <= '0;
              state   <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              act_q   <= act_shl;
              data_o  <= act_shl[W-1];
              state   <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (lat_done) begin
            latch_o      <= 1'b0;
            frame_done_o <= 1'b1;
            if (pend_v || start_i) begin
              act_q   <= launch_data;
              data_o  <= launch_data[W-1];
              bit_cnt <= '0;
              div_cnt <= '0;
              state   <= SHIFT_LO;
            end else begin
              busy_o  <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending buffer: latest start during a transfer wins, overwrite flags overrun
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q    <= '0;
      pend_v    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (start_i && (state != IDLE) && !(lat_done && !pend_v)) begin
        // On the last LATCH cycle the old pending frame is being launched, so no overrun
        pend_q    <= data_ord;
        pend_v    <= 1'b1;
        overrun_o <= pend_v && !lat_done;
      end else if (lat_done && pend_v) begin
        pend_v <= 1'b0;
      end
    end
  end

`ifdef SEG_CHAIN_DRIVER_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] pwm_nxt;
  logic [3:0] bright_q;
  logic [3:0] bright_nxt;
  logic       latch_nxt;

  assign pwm_nxt    = pwm_cnt + 4'd1;
  assign bright_nxt = (pwm_cnt == 4'hF) ? brightness_i : bright_q;
  assign latch_nxt  = ((state == SHIFT_HI) && div_done && (bit_cnt == LAST_BIT)) ||
                      ((state == LATCH) && !lat_done);

  // Free-running PWM; brightness takes effect at each wrap, OE forced off while latching
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
      oe_n_o   <= 1'b1;
    end else begin
      pwm_cnt  <= pwm_nxt;
      bright_q <= bright_nxt;
      oe_n_o   <= latch_nxt || (pwm_nxt >= bright_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_seg_chain_driver.sv
// Bench for seg_chain_driver: directed frame table, multi-cycle corner
// sequences (divider config, pending/overrun, async reset) and a randomized
// run checked against a timeline model of the serial protocol.
module tb_seg_chain_driver;

  localparam int W   = 42;
  localparam int FL  = 2 * 1 * W + 1;      // frame length, default config
  localparam int W2  = 8;
  localparam int FL2 = 2 * 3 * W2 + 2;     // frame length, DIV=3 / LATCH=2 config

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0, lsb = 1'b0;
  logic [W-1:0] data = '0;
  logic         busy, sclk, sdat, latch, done, ovr;

  logic          start2 = 1'b0, lsb2 = 1'b0;
  logic [W2-1:0] data2 = '0;
  logic          busy2, sclk2, sdat2, latch2, done2, ovr2;

`ifdef SEG_CHAIN_DRIVER_DIM_EN
  logic [3:0] bright = 4'd0, bright2 = 4'd0;
  logic       oe_n, oe_n2;
`endif

  seg_chain_driver dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .data_i(data), .lsb_first_i(lsb),
`ifdef SEG_CHAIN_DRIVER_DIM_EN
    .brightness_i(bright), .oe_n_o(oe_n),
`endif
    .busy_o(busy), .sclk_o(sclk), .data_o(sdat), .latch_o(latch),
    .frame_done_o(done), .overrun_o(ovr)
  );

  seg_chain_driver #(.NUM_DIGITS(2), .SEG_WIDTH(4), .SCLK_DIV(3), .LATCH_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2), .data_i(data2), .lsb_first_i(lsb2),
`ifdef SEG_CHAIN_DRIVER_DIM_EN
    .brightness_i(bright2), .oe_n_o(oe_n2),
`endif
    .busy_o(busy2), .sclk_o(sclk2), .data_o(sdat2), .latch_o(latch2),
    .frame_done_o(done2), .overrun_o(ovr2)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Model of the external chain: shift on sclk rise, snapshot on latch rise
  logic [W-1:0] cap = '0;
  logic         psclk = 1'b0, plat = 1'b0;
  logic [W-1:0] frames[$];
  always @(negedge clk) begin
    if (sclk && !psclk) cap = {cap[W-2:0], sdat};
    if (latch && !plat) frames.push_back(cap);
    psclk = sclk;
    plat  = latch;
  end

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic [W-1:0] cap;     // word the chain holds after latching
    int           rises;
    int           lat_k;
    int           done_k;
  } dvec_t;

  // One frame from cycle 0 (start high); checks timing and delivered word
  task automatic run_dir(input dvec_t v, input int idx);
    int rises = 0, bad = 0, brise = -1, bfall = -1, lfirst = -1, lcnt = 0, dk = -1;
    logic ps = 1'b0;
    frames.delete();
    @(negedge clk); start = 1'b1; data = v.d; lsb = v.l;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k > 1) @(negedge clk);
      if (busy && brise < 0) brise = k;
      if (!busy && brise >= 0 && bfall < 0) bfall = k;
      if (sclk && !ps) begin rises++; if (k != 2 * rises) bad++; end
      ps = sclk;
      if (latch) begin lcnt++; if (lfirst < 0) lfirst = k; end
      if (done && dk < 0) dk = k;
    end
    chk($sformatf("dir%0d_busy_rise", idx), 64'(brise), 64'(1));
    chk($sformatf("dir%0d_sclk_rises", idx), 64'(rises), 64'(v.rises));
    chk($sformatf("dir%0d_rise_pos", idx), 64'(bad), 64'(0));
    chk($sformatf("dir%0d_latch_cycle", idx), 64'(lfirst), 64'(v.lat_k));
    chk($sformatf("dir%0d_latch_len", idx), 64'(lcnt), 64'(1));
    chk($sformatf("dir%0d_done_cycle", idx), 64'(dk), 64'(v.done_k));
    chk($sformatf("dir%0d_busy_fall", idx), 64'(bfall), 64'(v.done_k));
    chk($sformatf("dir%0d_frames", idx), 64'(frames.size()), 64'(1));
    if (frames.size() > 0) chk($sformatf("dir%0d_word", idx), 64'(frames[0]), 64'(v.cap));
  endtask

  // Divider/latch-length configuration on the second instance
  task automatic run_div3;
    int rises = 0, bad = 0, first = -1, prev = -1, lcnt = 0, dk = -1, brise = -1;
    logic ps = 1'b0;
    logic [W2-1:0] c2 = '0;
    @(negedge clk); start2 = 1'b1; data2 = 8'hA5; lsb2 = 1'b0;
    @(negedge clk); start2 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clk);
      if (busy2 && brise < 0) brise = k;
      if (sclk2 && !ps) begin
        rises++;
        c2 = {c2[W2-2:0], sdat2};
        if (first < 0) first = k;
        else if (k - prev != 6) bad++;
        prev = k;
      end
      ps = sclk2;
      if (latch2) lcnt++;
      if (done2 && dk < 0) dk = k;
    end
    chk("div3_busy_rise", 64'(brise), 64'(1));
    chk("div3_first_rise", 64'(first), 64'(4));
    chk("div3_rises", 64'(rises), 64'(W2));
    chk("div3_period", 64'(bad), 64'(0));
    chk("div3_latch_len", 64'(lcnt), 64'(2));
    chk("div3_done_cycle", 64'(dk), 64'(1 + FL2));
    chk("div3_word", 64'(c2), 64'(8'hA5));
  endtask

  // A at 0, B at 10, C at 20: B overwritten, C follows A with no gap
  task automatic run_overrun;
    logic [W-1:0] fa = 42'h0F0_F0F0_F0F0, fb = 42'h111_1111_1111, fc = 42'h3C3_C3C3_C3C3;
    int novr = 0, ovk = -1, gap = 0;
    int dks[$];
    logic [2:0] c86 = '0;
    logic s87 = 1'b0;
    frames.delete();
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (ovr) begin novr++; ovk = k; end
        if (done) dks.push_back(k);
        if (k < 2 * FL + 1 && !busy) gap++;
        if (k == 86) c86 = {busy, sclk, latch};
        if (k == 87) s87 = sclk;
      end
      start = (k == 0) || (k == 10) || (k == 20);
      data  = (k == 0) ? fa : (k == 10) ? fb : fc;
      lsb   = 1'b0;
    end
    start = 1'b0;
    chk("ovr_pulses", 64'(novr), 64'(1));
    chk("ovr_cycle", 64'(ovk), 64'(21));
    chk("ovr_busy_gap", 64'(gap), 64'(0));
    chk("ovr_c_launch", 64'(c86), 64'(3'b100));
    chk("ovr_c_first_rise", 64'(s87), 64'(1));
    chk("ovr_done_count", 64'(dks.size()), 64'(2));
    if (dks.size() == 2) chk("ovr_done_2nd", 64'(dks[1]), 64'(2 * FL + 1));
    chk("ovr_frames", 64'(frames.size()), 64'(2));
    if (frames.size() == 2) begin
      chk("ovr_frame_a", 64'(frames[0]), 64'(fa));
      chk("ovr_frame_c", 64'(frames[1]), 64'(fc));
    end
  endtask

  // Reset in the middle of a frame with a frame pending
  task automatic run_reset;
    logic [W-1:0] ff = 42'h2DB_6DB6_DB6D;
    int ndone = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 0) || (k == 20);
      data  = (k == 0) ? 42'h155_5555_5555 : 42'h0AB_CDEF_0123;
      lsb   = 1'b0;
    end
    start = 1'b0;
    chk("rst_pre_busy_sclk", 64'({busy, sclk}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'({busy, sclk, sdat, latch, done, ovr}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frames.delete();
    @(negedge clk); start = 1'b1; data = ff; lsb = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    chk("rst_after_frames", 64'(frames.size()), 64'(1));
    if (frames.size() > 0) chk("rst_after_word", 64'(frames[0]), 64'(ff));
    chk("rst_after_done", 64'(ndone), 64'(1));
    chk("rst_after_idle", 64'(busy), 64'(0));
  endtask

  // Randomized starts against a timeline model of frames and the pending slot
  task automatic run_random(input int ncyc);
    logic         m_act = 1'b0, m_pend = 1'b0, m_l = 1'b0, m_pl = 1'b0, s, l;
    logic [W-1:0] m_d = '0, m_pd = '0, d;
    int           m_first = 0, m_end = 0, rel, idx;
    logic [5:0]   exp_o = '0;   // {busy, sclk, data, latch, done, overrun}
    logic         e_sclk, e_dat, e_lat, e_done, e_ovr;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      chk($sformatf("rand_c%0d", t), 64'({busy, sclk, sdat, latch, done, ovr}), 64'(exp_o));
      // a start on the very last LATCH cycle is left to the directed tests
      s = ($urandom_range(0, 24) == 0) && !(m_act && (t + 1 == m_end));
      d = W'({$urandom(), $urandom()});
      l = 1'($urandom_range(0, 1));
      start = s; data = d; lsb = l;
      e_ovr = 1'b0; e_done = 1'b0;
      if (!m_act) begin
        if (s) begin m_act = 1'b1; m_first = t + 1; m_end = t + 1 + FL; m_d = d; m_l = l; end
      end else if (s) begin
        if (m_pend) e_ovr = 1'b1;
        m_pend = 1'b1; m_pd = d; m_pl = l;
      end
      if (m_act && (t + 1 == m_end)) begin
        e_done = 1'b1;
        if (m_pend) begin
          m_first = t + 1; m_end = t + 1 + FL; m_d = m_pd; m_l = m_pl; m_pend = 1'b0;
        end else begin
          m_act = 1'b0;
        end
      end
      e_sclk = 1'b0; e_dat = 1'b0; e_lat = 1'b0;
      if (m_act) begin
        rel = t + 1 - m_first;
        if (rel < 2 * W) begin
          idx    = rel / 2;
          e_sclk = 1'(rel % 2);
          e_dat  = m_l ? m_d[idx] : m_d[W-1-idx];
        end else begin
          e_lat = 1'b1;
        end
      end
      exp_o = {m_act, e_sclk, e_dat, e_lat, e_done, e_ovr};
    end
    start = 1'b0;
    repeat (2 * FL + 10) @(negedge clk);
  endtask

`ifdef SEG_CHAIN_DRIVER_DIM_EN
  task automatic run_dim(input logic [3:0] b, input int exp_low);
    int low = 0;
    bright = b;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!oe_n) low++;
    end
    chk($sformatf("dim_b%0d_low", b), 64'(low), 64'(exp_low));
  endtask
`endif

  dvec_t vecs[4];

  initial begin
    vecs[0] = '{42'h2AA_AAAA_AAAA, 1'b0, 42'h2AA_AAAA_AAAA, 42, 85, 86};
    vecs[1] = '{42'h000_0000_0001, 1'b1, 42'h200_0000_0000, 42, 85, 86};
    vecs[2] = '{42'h3FF_0000_0001, 1'b1, 42'h200_0000_03FF, 42, 85, 86};
    vecs[3] = '{42'h123_4567_89AB, 1'b0, 42'h123_4567_89AB, 42, 85, 86};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, sclk, sdat, latch, done, ovr}), 64'(0));
    chk("reset_outputs2", 64'({busy2, sclk2, sdat2, latch2, done2, ovr2}), 64'(0));
`ifdef SEG_CHAIN_DRIVER_DIM_EN
    chk("reset_oe_n", 64'(oe_n), 64'(1));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_dir(vecs[i], i);
    run_div3();
    run_overrun();
    run_reset();
    run_random(3000);
`ifdef SEG_CHAIN_DRIVER_DIM_EN
    run_dim(4'd4, 16);
    run_dim(4'd0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
